pipeline_perf_counters: RTL
===========================

Name: pipeline_perf_counters

Overview:
Performance-counter block inside pipelined_cpu, directly downstream of the WB/MEM stages and the hazard unit.
- Consumes per-cycle retire, store, stall and flush strobes.
- Keeps run-controlled live counters and copies them into a shadow bank on request.
- Exposes shadow values through a registered read port, so benches and debug logic read cycle/instruction/CPI data without probing pipeline internals.

Parameters:
CNT_WIDTH, 64, width of every counter and of rd_data
NUM_CNT, 5, number of implemented counters; fixed, not user-overridable

Ports:
clk  input  1  clock
rst  input  1  reset
start  input  1  pulse: enter RUN
stop  input  1  pulse: enter FROZEN
clear  input  1  pulse: zero live counters and ovf
wb_retire  input  1  WB-stage instruction with RegWrite completes
mem_store  input  1  MEM-stage store completes
hazard_stall  input  1  pipeline stalled this cycle
flush  input  1  pipeline flushed this cycle
snap_req  input  1  pulse: copy live counters to shadow
snap_done  output  1  one-cycle pulse, shadow updated
rd_req  input  1  pulse: read shadow[rd_sel]
rd_sel  input  3  counter index
rd_valid  output  1  one-cycle pulse, rd_data valid
rd_data  output  CNT_WIDTH  selected shadow value
ovf  output  5  sticky per-counter overflow flags
running  output  1  high in RUN

Behaviour:
- Reset rst, synchronous, active-high; clock clk.
- Reset values: state=IDLE; all live and shadow counters 0; ovf=0; snap_done=0; rd_valid=0; rd_data=0; running=0.
- FSM states IDLE, RUN, FROZEN.
  - IDLE --start--> RUN.
  - RUN --stop--> FROZEN.
  - FROZEN --start--> RUN.
  - start and stop in the same cycle: stop wins. From IDLE this means no transition.
- running=1 exactly in RUN. Strobes sampled in the cycle the FSM enters RUN are not counted; counting begins the cycle after.
- Counters increment only in RUN, on the clk edge at which the strobe is sampled:
  - C0 cycles: +1 every RUN cycle.
  - C1 retired: + (wb_retire + mem_store), i.e. 0, 1 or 2.
  - C2 stalls: +1 when hazard_stall.
  - C3 flushes: +1 when flush.
  - C4 stores: +1 when mem_store.
- clear: live counters := 0 and ovf := 0 at the edge. Clear overrides any increment in the same cycle. FSM state unchanged. Shadow unchanged.
- Overflow: an increment that carries out of CNT_WIDTH sets ovf[i] sticky. For C1, +2 from all-ones-minus-1 or from all-ones counts as overflow. Wrap vs saturate is set by the optional feature.
- Snapshot:
  - snap_req sampled at edge N: shadow[i] := live[i] register value before edge N's increment.
  - snap_done=1 during cycle N+1 only.
  - Back-to-back snap_req each takes effect; no busy state.
- Read:
  - rd_req at edge N: rd_data := shadow[rd_sel] (value before any snapshot at the same edge); rd_valid=1 in cycle N+1.
  - rd_sel 5..7 returns 0.
  - rd_data holds its value until the next rd_req.
- Reset mid-operation discards everything, including a pending snap_done or rd_valid.

Optional Feature:
PERF_SAT_EN
- Defined: counters saturate at all-ones, never wrap, and still set ovf.
- Undefined: counters wrap modulo 2^CNT_WIDTH and set ovf on wrap.

Test Plan:
- Reset, start, 10 idle cycles, stop, snap_req, rd_req sel 0 -> snap_done one cycle; rd_valid next cycle; rd_data=10; ovf=0.
- In RUN, 6 cycles wb_retire=1 including 2 with mem_store=1, 3 with hazard_stall=1, 1 flush -> C1=8, C2=3, C3=1, C4=2.
- start and stop together while IDLE -> stays IDLE, running=0. While RUN -> FROZEN, counters hold over 20 further strobe cycles.
- clear asserted during a wb_retire cycle -> C1=0 next cycle. Shadow still returns the pre-clear snapshot value. FSM stays RUN.
- CNT_WIDTH=4, 17 RUN cycles -> without PERF_SAT_EN C0=1, ovf[0]=1; with PERF_SAT_EN C0=15, ovf[0]=1.
- rd_sel=6 read -> rd_data=0. snap_req and rd_req in the same cycle -> read returns the old shadow value; a following read returns the new one.

Source files
------------

// File: rtl/pipeline_perf_counters.sv
// Pipeline performance counters: run-controlled live bank, shadow snapshot, registered read port.
// Build option PERF_SAT_EN: counters saturate at all-ones instead of wrapping.
module pipeline_perf_counters #(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 clear,
    input  logic                 wb_retire,
    input  logic                 mem_store,
    input  logic                 hazard_stall,
    input  logic                 flush,
    input  logic                 snap_req,
    output logic                 snap_done,
    input  logic                 rd_req,
    input  logic [2:0]           rd_sel,
    output logic                 rd_valid,
    output logic [CNT_WIDTH-1:0] rd_data,
    output logic [4:0]           ovf,
    output logic                 running
);

    localparam int NUM_CNT = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FROZEN
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] live_q   [NUM_CNT];
    logic [CNT_WIDTH-1:0] live_d   [NUM_CNT];
    logic [CNT_WIDTH-1:0] shadow_q [NUM_CNT];
    logic [CNT_WIDTH-1:0] shadow_d [NUM_CNT];
    logic [NUM_CNT-1:0]   ovf_q, ovf_d;
    logic                 snap_done_q, snap_done_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [1:0]           inc      [NUM_CNT];
    logic [CNT_WIDTH:0]   sum      [NUM_CNT];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start && !stop) state_d = ST_RUN;
            ST_RUN:    if (stop) state_d = ST_FROZEN;
            ST_FROZEN: if (start && !stop) state_d = ST_RUN;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        inc[0] = 2'd1;
        inc[1] = {1'b0, wb_retire} + {1'b0, mem_store};
        inc[2] = {1'b0, hazard_stall};
        inc[3] = {1'b0, flush};
        inc[4] = {1'b0, mem_store};
    end

    // Extra top bit of sum is the carry-out; it covers C1's +2 past all-ones too.
    always_comb begin
        ovf_d = ovf_q;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            sum[i]      = {1'b0, live_q[i]} + {{(CNT_WIDTH-1){1'b0}}, inc[i]};
            live_d[i]   = live_q[i];
            shadow_d[i] = snap_req ? live_q[i] : shadow_q[i];
            if (clear) begin
                live_d[i] = '0;
            end else if (state_q == ST_RUN) begin
                if (sum[i][CNT_WIDTH]) begin
                    ovf_d[i] = 1'b1;
`ifdef PERF_SAT_EN
                    live_d[i] = '1;
`else
                    live_d[i] = sum[i][CNT_WIDTH-1:0];
`endif
                end else begin
                    live_d[i] = sum[i][CNT_WIDTH-1:0];
                end
            end
        end
        if (clear) ovf_d = '0;
    end

    // Read samples the shadow register value, so a same-edge snapshot is not visible yet.
    always_comb begin
        snap_done_d = snap_req;
        rd_valid_d  = rd_req;
        rd_data_d   = rd_data_q;
        if (rd_req) begin
            case (rd_sel)
                3'd0:    rd_data_d = shadow_q[0];
                3'd1:    rd_data_d = shadow_q[1];
                3'd2:    rd_data_d = shadow_q[2];
                3'd3:    rd_data_d = shadow_q[3];
                3'd4:    rd_data_d = shadow_q[4];
                default: rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ovf_q       <= '0;
            snap_done_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                live_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ovf_q       <= ovf_d;
            snap_done_q <= snap_done_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                live_q[i]   <= live_d[i];
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign snap_done = snap_done_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign ovf       = ovf_q;
    assign running   = (state_q == ST_RUN);

endmodule
